// File: rtl/id_ex_stage.sv
// RV32I decode plus ID/EX pipeline register feeding the ALU.
// Optional operand forwarding from MEM/WB is enabled with `define ID_EX_FWD_EN.
module id_ex_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [31:0]     id_inst,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            stall,
   input  logic            flush,
`ifdef ID_EX_FWD_EN
   input  logic            fwd_mem_en,
   input  logic [4:0]      fwd_mem_rd,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic            fwd_wb_en,
   input  logic [4:0]      fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_wb_data,
`endif
   output logic            ex_valid,
   output logic [3:0]      ex_alu_ctrl,
   output logic [XLEN-1:0] ex_in1,
   output logic [XLEN-1:0] ex_in2,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_target,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_is_branch,
   output logic            ex_is_jump,
   output logic            ex_illegal
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9;

   typedef struct packed {
      logic            valid;
      logic [3:0]      alu_ctrl;
      logic [XLEN-1:0] in1;
      logic [XLEN-1:0] in2;
      logic [XLEN-1:0] store_data;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            is_branch;
      logic            is_jump;
      logic            illegal;
   } ex_t;

   function automatic logic [3:0] alu_base(input logic [2:0] f);
      case (f)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [6:0]      opcode, f7;
   logic [2:0]      f3;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1, rs2;
   ex_t             d, ex_q;

   assign opcode = id_inst[6:0];
   assign f3     = id_inst[14:12];
   assign f7     = id_inst[31:25];
   assign imm_i  = {{20{id_inst[31]}}, id_inst[31:20]};
   assign imm_s  = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
   assign imm_b  = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
   assign imm_u  = {id_inst[31:12], 12'b0};
   assign imm_j  = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};

   // MEM is the younger producer, so it wins over WB.
   always_comb begin
      rs1 = id_rs1_data;
      rs2 = id_rs2_data;
`ifdef ID_EX_FWD_EN
      if (fwd_mem_en && fwd_mem_rd != 5'd0 && fwd_mem_rd == id_inst[19:15])
         rs1 = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_rd != 5'd0 && fwd_wb_rd == id_inst[19:15])
         rs1 = fwd_wb_data;
      if (fwd_mem_en && fwd_mem_rd != 5'd0 && fwd_mem_rd == id_inst[24:20])
         rs2 = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_rd != 5'd0 && fwd_wb_rd == id_inst[24:20])
         rs2 = fwd_wb_data;
`endif
   end

   always_comb begin
      d            = '0;
      d.valid      = 1'b1;
      d.pc         = id_pc;
      d.rd         = id_inst[11:7];
      d.funct3     = f3;
      d.store_data = rs2;
      d.alu_ctrl   = ALU_ADD;
      case (opcode)
         OP_R: begin
            d.in1       = rs1;
            d.in2       = rs2;
            d.reg_write = 1'b1;
            if (f7 == 7'h00)
               d.alu_ctrl = alu_base(f3);
            else if (f7 == 7'h20 && f3 == 3'b000)
               d.alu_ctrl = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'b101)
               d.alu_ctrl = ALU_SRA;
            else
               d.illegal = 1'b1;
         end
         OP_I: begin
            d.in1       = rs1;
            d.reg_write = 1'b1;
            d.in2       = (f3[1:0] == 2'b01) ? {27'b0, imm_i[4:0]} : imm_i;
            d.alu_ctrl  = (f3 == 3'b101 && f7[5]) ? ALU_SRA : alu_base(f3);
         end
         OP_LD: begin
            d.in1       = rs1;
            d.in2       = imm_i;
            d.mem_read  = 1'b1;
            d.reg_write = 1'b1;
            d.illegal   = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_ST: begin
            d.in1       = rs1;
            d.in2       = imm_s;
            d.mem_write = 1'b1;
            d.illegal   = (f3 > 3'b010);
         end
         OP_BR: begin
            d.in1       = rs1;
            d.in2       = rs2;
            d.target    = id_pc + imm_b;
            d.is_branch = 1'b1;
            // 000/001 -> 10/11, 1xx -> 12..15
            d.alu_ctrl  = f3[2] ? {2'b11, f3[1:0]} : {3'b101, f3[0]};
            d.illegal   = (f3[2:1] == 2'b01);
         end
         OP_LUI: begin
            d.in2       = imm_u;
            d.reg_write = 1'b1;
         end
         OP_AUI: begin
            d.in1       = id_pc;
            d.in2       = imm_u;
            d.reg_write = 1'b1;
         end
         OP_JAL: begin
            d.in1       = id_pc;
            d.in2       = 32'd4;
            d.target    = id_pc + imm_j;
            d.is_jump   = 1'b1;
            d.reg_write = 1'b1;
         end
         OP_JALR: begin
            d.in1       = id_pc;
            d.in2       = 32'd4;
            d.target    = (rs1 + imm_i) & ~32'd1;
            d.is_jump   = 1'b1;
            d.reg_write = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      if (d.illegal) begin
         d.alu_ctrl  = ALU_ADD;
         d.reg_write = 1'b0;
         d.mem_read  = 1'b0;
         d.mem_write = 1'b0;
         d.is_branch = 1'b0;
         d.is_jump   = 1'b0;
      end
      if (d.rd == 5'd0)
         d.reg_write = 1'b0;
   end

   // A missing instruction is treated exactly like a flush, but only when not stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         ex_q.pc <= RESET_PC;
      end else if (flush || (!stall && !id_valid)) begin
         ex_q <= '0;
      end else if (!stall) begin
         ex_q <= d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_alu_ctrl   = ex_q.alu_ctrl;
   assign ex_in1        = ex_q.in1;
   assign ex_in2        = ex_q.in2;
   assign ex_store_data = ex_q.store_data;
   assign ex_target     = ex_q.target;
   assign ex_pc         = ex_q.pc;
   assign ex_rd         = ex_q.rd;
   assign ex_funct3     = ex_q.funct3;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_is_branch  = ex_q.is_branch;
   assign ex_is_jump    = ex_q.is_jump;
   assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plan items, then random instructions built from
// chosen semantics (operation, operands, immediate value) checked against a stage model.
module tb_id_ex_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk, rst, id_valid, stall, flush;
   logic [31:0] id_inst, id_pc, id_rs1_data, id_rs2_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal;
   logic [3:0]  ex_alu_ctrl;
   logic [31:0] ex_in1, ex_in2, ex_store_data, ex_target, ex_pc;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
`ifdef ID_EX_FWD_EN
   logic        fwd_mem_en = 0, fwd_wb_en = 0;
   logic [4:0]  fwd_mem_rd = 0, fwd_wb_rd = 0;
   logic [31:0] fwd_mem_data = 0, fwd_wb_data = 0;
`endif

   int pass_cnt = 0, tot_cnt = 0;

   id_ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
`ifdef ID_EX_FWD_EN
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
`endif
      .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_in1(ex_in1), .ex_in2(ex_in2),
      .ex_store_data(ex_store_data), .ex_target(ex_target), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
      .ex_illegal(ex_illegal)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        v, ill, rw, mr, mw, br, jmp;
      logic [3:0]  ctrl;
      logic [31:0] in1, in2, sd, tgt, pc;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        c_all, c_ops, c_rd, c_sd, c_tgt, c_f3;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input logic r, f, s, v, input logic [31:0] inst, pc, a, b);
      rst = r; flush = f; stall = s; id_valid = v;
      id_inst = inst; id_pc = pc; id_rs1_data = a; id_rs2_data = b;
      @(posedge clk);
      #1;
   endtask

   // funct3 encodings indexed by ALU code (ADD..AND) and by branch code minus 10
   function automatic logic [2:0] f3_of(input int k);
      case (k)
         0, 1: return 3'd0;
         2: return 3'd1;
         3: return 3'd2;
         4: return 3'd3;
         5: return 3'd4;
         6, 7: return 3'd5;
         8: return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [2:0] br_f3(input int k);
      case (k)
         0: return 3'd0; 1: return 3'd1; 2: return 3'd4; 3: return 3'd5;
         4: return 3'd6; 5: return 3'd7; 6: return 3'd2; default: return 3'd3;
      endcase
   endfunction

   task automatic gen(input logic [31:0] pc, a, b, output logic [31:0] inst, output exp_t e);
      int kind, k, v, t;
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic [19:0] u;
      logic [6:0]  opc;
      e = '0;
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      e.v = 1; e.pc = pc; e.rd = rd; e.c_ops = 1;
      v = int'($urandom_range(0, 4095)) - 2048;
      kind = $urandom_range(0, 9);
      case (kind)
         0: begin
            k = $urandom_range(0, 9);
            inst = {(k == 1 || k == 7) ? 7'h20 : 7'h00, r2, r1, f3_of(k), rd, 7'h33};
            if ($urandom_range(0, 7) == 0) begin inst[31:25] = 7'h01; e.ill = 1; end
            e.ctrl = 4'(k); e.in1 = a; e.in2 = b; e.rw = 1; e.c_rd = 1;
         end
         1: begin
            k = $urandom_range(0, 8);
            if (k >= 1) k++;
            if (k == 2 || k == 6 || k == 7) begin
               v = $urandom_range(0, 31);
               inst = {(k == 7) ? 7'h20 : 7'h00, v[4:0], r1, f3_of(k), rd, 7'h13};
            end else
               inst = {v[11:0], r1, f3_of(k), rd, 7'h13};
            e.ctrl = 4'(k); e.in1 = a; e.in2 = 32'(v); e.rw = 1; e.c_rd = 1;
         end
         2: begin
            t = $urandom_range(0, 5);
            if (t == 5) begin f3 = 3'd6; e.ill = 1; end
            else f3 = (t < 3) ? 3'(t) : 3'(t + 1);
            inst = {v[11:0], r1, f3, rd, 7'h03};
            e.in1 = a; e.in2 = 32'(v); e.mr = 1; e.rw = 1; e.c_rd = 1; e.c_f3 = 1; e.f3 = f3;
         end
         3: begin
            f3 = 3'($urandom_range(0, 3));
            if (f3 == 3'd3) begin f3 = 3'($urandom_range(3, 7)); e.ill = 1; end
            inst = {v[11:5], r2, r1, f3, v[4:0], 7'h23};
            e.in1 = a; e.in2 = 32'(v); e.mw = 1; e.sd = b; e.c_sd = 1; e.c_f3 = 1; e.f3 = f3;
         end
         4: begin
            k = $urandom_range(0, 7);
            v = v * 2;
            inst = {v[12], v[10:5], r2, r1, br_f3(k), v[4:1], v[11], 7'h63};
            e.ctrl = 4'(10 + k); e.in1 = a; e.in2 = b; e.tgt = pc + 32'(v); e.br = 1; e.c_tgt = 1;
            if (k >= 6) e.ill = 1;
         end
         5, 6: begin
            u = 20'($urandom);
            inst = {u, rd, (kind == 5) ? 7'h37 : 7'h17};
            e.in1 = (kind == 5) ? 32'd0 : pc; e.in2 = {u, 12'h000}; e.rw = 1; e.c_rd = 1;
         end
         7: begin
            v = 2 * (int'($urandom_range(0, 1048575)) - 524288);
            inst = {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
            e.in1 = pc; e.in2 = 4; e.tgt = pc + 32'(v); e.jmp = 1; e.rw = 1; e.c_rd = 1; e.c_tgt = 1;
         end
         8: begin
            inst = {v[11:0], r1, 3'b000, rd, 7'h67};
            e.in1 = pc; e.in2 = 4; e.tgt = (a + 32'(v)) & ~32'd1;
            e.jmp = 1; e.rw = 1; e.c_rd = 1; e.c_tgt = 1;
         end
         default: begin
            t = $urandom_range(0, 3);
            opc = (t == 0) ? 7'h7F : (t == 1) ? 7'h0B : (t == 2) ? 7'h5B : 7'h2F;
            inst = {25'($urandom), opc};
            e.ill = 1;
         end
      endcase
      if (e.ill) begin
         e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jmp = 0; e.ctrl = 0;
         e.c_ops = 0; e.c_rd = 0; e.c_sd = 0; e.c_tgt = 0; e.c_f3 = 0;
      end
      if (rd == 5'd0) e.rw = 0;
   endtask

   task automatic check_all(input exp_t e);
      chk("flags", {21'd0, ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write,
                    ex_is_branch, ex_is_jump, ex_alu_ctrl},
          {21'd0, e.v, e.ill, e.rw, e.mr, e.mw, e.br, e.jmp, e.ctrl});
      if (e.c_all || e.v) chk("pc", ex_pc, e.pc);
      if (e.c_all || e.c_ops) begin
         chk("in1", ex_in1, e.in1);
         chk("in2", ex_in2, e.in2);
      end
      if (e.c_all || e.c_rd)  chk("rd", {27'd0, ex_rd}, {27'd0, e.rd});
      if (e.c_all || e.c_sd)  chk("store_data", ex_store_data, e.sd);
      if (e.c_all || e.c_tgt) chk("target", ex_target, e.tgt);
      if (e.c_all || e.c_f3)  chk("funct3", {29'd0, ex_funct3}, {29'd0, e.f3});
   endtask

   initial begin
      exp_t        model, cand, rst_e, bub_e;
      logic        r, f, s, v;
      logic [31:0] inst, pc, a, b;

      rst_e = '0; rst_e.c_all = 1; rst_e.pc = RST_PC;
      bub_e = '0; bub_e.c_all = 1;

      // reset state
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check_all(rst_e);

      // addi x5,x1,-3
      step(0, 0, 0, 1, 32'hFFD08293, 32'h100, 10, 0);
      chk("addi.ctrl", ex_alu_ctrl, 0);
      chk("addi.in1", ex_in1, 10);
      chk("addi.in2", ex_in2, 32'hFFFFFFFD);
      chk("addi.rd", ex_rd, 5);
      chk("addi.rw", ex_reg_write, 1);
      chk("addi.valid", ex_valid, 1);
      chk("addi.pc", ex_pc, 32'h100);

      // sub x3,x1,x2 / srai x4,x1,4
      step(0, 0, 0, 1, 32'h402081B3, 32'h104, 9, 4);
      chk("sub.ctrl", ex_alu_ctrl, 1);
      chk("sub.in1", ex_in1, 9);
      chk("sub.in2", ex_in2, 4);
      step(0, 0, 0, 1, 32'h4040D213, 32'h108, 32'h80000000, 0);
      chk("srai.ctrl", ex_alu_ctrl, 7);
      chk("srai.in2", ex_in2, 4);

      // beq x1,x2,+8
      step(0, 0, 0, 1, 32'h00208463, 32'h200, 1, 1);
      chk("beq.ctrl", ex_alu_ctrl, 10);
      chk("beq.br", ex_is_branch, 1);
      chk("beq.target", ex_target, 32'h208);
      chk("beq.rw", ex_reg_write, 0);

      // stall holds for three cycles despite a new instruction
      step(0, 0, 0, 1, 32'hFFD08293, 32'h300, 10, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 32'h402081B3, 32'h304, 9, 4);
         chk("stall.ctrl", ex_alu_ctrl, 0);
         chk("stall.in2", ex_in2, 32'hFFFFFFFD);
         chk("stall.pc", ex_pc, 32'h300);
      end
      step(0, 1, 1, 1, 32'h402081B3, 32'h304, 9, 4);
      chk("flush.valid", ex_valid, 0);
      chk("flush.flags", {ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal}, 0);

      // illegal opcode, addi to x0
      step(0, 0, 0, 1, 32'h0000007F, 32'h400, 0, 0);
      chk("ill.illegal", ex_illegal, 1);
      chk("ill.valid", ex_valid, 1);
      chk("ill.rw", ex_reg_write, 0);
      chk("ill.ctrl", ex_alu_ctrl, 0);
      step(0, 0, 0, 1, 32'hFFD08013, 32'h404, 10, 0);
      chk("x0.rw", ex_reg_write, 0);
      chk("x0.valid", ex_valid, 1);

      // reset wins over stall
      step(1, 0, 1, 1, 32'hFFD08293, 32'h500, 10, 0);
      check_all(rst_e);

`ifdef ID_EX_FWD_EN
      fwd_mem_en = 1; fwd_mem_rd = 1; fwd_mem_data = 32'h55;
      fwd_wb_en = 1; fwd_wb_rd = 1; fwd_wb_data = 32'h66;
      step(0, 0, 0, 1, 32'h002081B3, 32'h600, 1, 2);
      chk("fwd.mem_over_wb", ex_in1, 32'h55);
      chk("fwd.no_rs2", ex_in2, 2);
      fwd_wb_rd = 2; fwd_wb_data = 32'h77;
      step(0, 0, 0, 1, 32'h002081B3, 32'h600, 1, 2);
      chk("fwd.in1", ex_in1, 32'h55);
      chk("fwd.in2", ex_in2, 32'h77);
      fwd_mem_en = 0; fwd_wb_en = 0;
`endif

      // randomized traffic against the stage model
      step(1, 0, 0, 0, 0, 0, 0, 0);
      model = rst_e;
      check_all(model);
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 99) < 3);
         f = ($urandom_range(0, 99) < 10);
         s = ($urandom_range(0, 99) < 20);
         v = ($urandom_range(0, 99) < 85);
         pc = $urandom & ~32'd3; a = $urandom; b = $urandom;
         gen(pc, a, b, inst, cand);
         step(r, f, s, v, inst, pc, a, b);
         if (r) model = rst_e;
         else if (f || (!s && !v)) model = bub_e;
         else if (!s) model = cand;
         check_all(model);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
